imem_loader: RTL
================

# imem_loader

Boot sequencer for the single-cycle RV32 core. Holds the core in reset while a program image arrives byte-by-byte from the UART receiver, assembles little-endian 32-bit words, writes them into instruction memory, and verifies an XOR checksum. It releases the core to run from PC 0 only after a complete, checksum-clean image. The block sits between the UART RX, the instruction-memory write port and the core's reset input.

## Interface
- ADDR_W, 10: instruction-memory word-address width; maximum image is 2**ADDR_W words.
- TIMEOUT, 1000000: idle cycles allowed between received bytes before a load aborts; must be ≥ 2.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse, already synchronised; begins or restarts a load.
- rx_valid  in  1  one-cycle strobe; rx_data holds a valid byte.
- rx_data  in  8  received byte.
- imem_we  out  1  instruction-memory write enable, exactly one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word data for the write.
- cpu_reset  out  1  active-high reset to the core; 1 except in RUN.
- busy  out  1  high in HDR, DATA and CHK.
- done  out  1  high in RUN.
- error  out  1  high in ERROR.
- word_count  out  ADDR_W+1  words written in the current load.

## Operation
- States: IDLE, HDR, DATA, CHK, RUN, ERROR. All outputs are registered.
- Reset values: state IDLE, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, word_count=0. The internal length, byte index, word accumulator, checksum accumulator and timeout counter also clear to 0.
- IDLE, ERROR, RUN:
  - rx_valid is ignored.
  - start moves to HDR and clears byte index, word_count, length, checksum accumulator and timeout counter.
- HDR:
  - Collects 4 bytes into length L, little-endian; the first byte goes to bits 7:0.
  - After the 4th byte: if L==0 or L>2**ADDR_W, go to ERROR; otherwise go to DATA.
- DATA:
  - Collects 4 bytes per word, little-endian.
  - On the 4th byte: imem_wdata=word, imem_addr=word_count[ADDR_W-1:0], imem_we=1; word_count increments; checksum accumulator ^= word.
  - When word_count reaches L, go to CHK.
- CHK:
  - Collects a 4-byte little-endian checksum word.
  - Match with the accumulator goes to RUN; mismatch goes to ERROR.
- start is ignored in HDR, DATA and CHK. Reloading requires ERROR, RUN or a reset.
- Timeout (HDR, DATA, CHK only):
  - The counter clears on state entry and on each accepted byte, and increments otherwise.
  - When it reaches TIMEOUT-1 with no byte that cycle, go to ERROR.
  - A byte arriving in that same cycle is accepted and no error occurs.
- Simultaneous start and rx_valid in IDLE/RUN/ERROR: start takes effect and the byte is discarded.
- Reset mid-load: state returns to IDLE immediately and asynchronously, and imem_we drops at once. Words already written stay in memory; the core remains held in reset.
- word_count is not cleared on entering RUN or ERROR; it reports the progress of the last load.

## Timing
- A byte on rx_valid at edge n updates internal state at edge n.
- The imem_we pulse for a word is visible in the cycle after the edge that captured its 4th byte, and lasts exactly one cycle. At most one pulse occurs per 4 accepted bytes.
- Minimum byte spacing is 1 cycle (back-to-back rx_valid); write pulses then occur every 4th cycle.
- DATA→CHK happens on the same edge that registers the last write.
- The final checksum byte at edge n gives state RUN, cpu_reset=0 and done=1 after edge n; the core fetches PC=0 from edge n+1.
- start in RUN at edge n gives cpu_reset=1 and busy=1 after edge n.
- busy, done and error are mutually exclusive; all three are 0 in IDLE.

## Test plan
- Load L=2, words 0x00000013 and 0x00100093, checksum 0x00100080, all bytes back-to-back → two imem_we pulses: (addr 0, 0x00000013), then (addr 1, 0x00100093); then RUN with done=1, cpu_reset=0, word_count=2.
- Same image with checksum 0x00000000 → both writes occur, then ERROR with error=1 and cpu_reset=1; a subsequent start enters HDR with word_count=0.
- Header L=0, and separately L=2**ADDR_W+1 → ERROR directly after the 4th header byte; no imem_we pulse.
- TIMEOUT=16: after 5 DATA bytes, stop rx → ERROR exactly 16 cycles after the 5th byte; word_count=1. A byte delivered on the 16th cycle keeps the block in DATA.
- reset low for 1 cycle mid-DATA → all outputs at reset values immediately; the imem_we in flight is suppressed; rx bytes are then ignored until start.
- In RUN, pulse start together with rx_valid=0xAA → HDR with cpu_reset=1; byte 0xAA not counted; the following 4 bytes form L.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader: assembles an image into instruction memory, checks it, then releases the core
module imem_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_RUN, S_ERROR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   len_q;
  logic [31:0]   word_acc_q;
  logic [31:0]   chk_acc_q;
  logic [1:0]    byte_idx_q;
  logic [TW-1:0] tmo_q;

  logic [31:0]   asm_word;
  logic [ADDR_W:0] wc_inc;
  logic          loading, byte_ok, last_byte, last_word, tmo_exp;
  logic          we_d, busy_d, done_d, error_d, cpu_reset_d;

  assign loading   = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign byte_ok   = loading && rx_valid;
  assign last_byte = byte_ok && (byte_idx_q == 2'd3);
  assign tmo_exp   = !rx_valid && (tmo_q == TW'(TIMEOUT - 1));
  assign wc_inc    = word_count + (ADDR_W+1)'(1);
  assign last_word = (32'(wc_inc) == len_q);

  // Header bytes accumulate into the length register, all others into the word accumulator.
  always_comb begin
    asm_word = (state_q == S_HDR) ? len_q : word_acc_q;
    asm_word[{byte_idx_q, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: if (start) state_d = S_HDR;
      S_HDR: begin
        if (tmo_exp) state_d = S_ERROR;
        else if (last_byte)
          state_d = (asm_word == 32'd0 || asm_word > MAX_LEN) ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (tmo_exp) state_d = S_ERROR;
        else if (last_byte && last_word) state_d = S_CHK;
      end
      S_CHK: begin
        if (tmo_exp) state_d = S_ERROR;
        else if (last_byte) state_d = (asm_word == chk_acc_q) ? S_RUN : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered copies of the next state so they change on the same edge.
  always_comb begin
    we_d        = last_byte && (state_q == S_DATA);
    busy_d      = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERROR);
    cpu_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      len_q      <= '0;
      word_acc_q <= '0;
      chk_acc_q  <= '0;
      byte_idx_q <= '0;
      tmo_q      <= '0;
    end else begin
      imem_we   <= we_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      cpu_reset <= cpu_reset_d;
      if (!loading) begin
        if (start) begin
          byte_idx_q <= '0;
          word_count <= '0;
          len_q      <= '0;
          chk_acc_q  <= '0;
          tmo_q      <= '0;
        end
      end else if (rx_valid) begin
        tmo_q      <= '0;
        byte_idx_q <= byte_idx_q + 2'd1;
        if (state_q == S_HDR) len_q <= asm_word;
        else                  word_acc_q <= asm_word;
        if (we_d) begin
          imem_addr  <= word_count[ADDR_W-1:0];
          imem_wdata <= asm_word;
          word_count <= wc_inc;
          chk_acc_q  <= chk_acc_q ^ asm_word;
        end
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

endmodule
